// File: rtl/vga_pixel_out.sv
// vga_pixel_out
//   Pixel stage behind the 640x480@60 VGA timing generator. It pops RGB565
//   words from the frame-buffer read FIFO in step with the active area, and
//   re-times RGB, syncs and DE so that all of them leave two clocks after the
//   generator outputs they belong to. It keeps the upstream DMA frame-aligned
//   (frame_req / fifo_flush), and when the FIFO underflows it shows
//   FILL_COLOR until the next vertical blank.
//
//   Optional build macro: VGA_TEST_PATTERN_EN adds 8 full-scale colour bars
//   that test_pat_sel can select. With the macro undefined, test_pat_sel is
//   ignored.
//
// Ports
//   vga_pclk, sys_rst           pixel clock, async active-high reset
//   vga_paddr_h/v, vga_hsync,   timing generator outputs (syncs active-low)
//   vga_vsync, vga_dp_en
//   fifo_dout, fifo_empty,      read side of the frame FIFO; data is valid
//   fifo_rd_en                  one clock after the pop
//   fifo_flush, frame_req       one-cycle pulses to the FIFO / DMA
//   underflow_clr               synchronous clear of the underflow status
//   test_pat_sel                colour-bar select (only with VGA_TEST_PATTERN_EN)
//   vga_r/g/b, vga_hs_o,        aligned pixel outputs
//   vga_vs_o, vga_de_o
//   underflow, underflow_cnt    sticky flag and saturating event count
//
// FSM states
//   ST_IDLE    | after reset; wait for a vblank before trusting the DMA
//   ST_ARM     | DMA restarted; wait for pixel (0,0) to start popping
//   ST_RUN     | streaming FIFO data
//   ST_RECOVER | underflow hit; show fill colour until the next vblank

module vga_pixel_out #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter logic [15:0] FILL_COLOR = 16'h001F
) (
  input  logic        vga_pclk,
  input  logic        sys_rst,
  input  logic [9:0]  vga_paddr_h,
  input  logic [9:0]  vga_paddr_v,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic        vga_dp_en,
  input  logic [15:0] fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic        fifo_flush,
  output logic        frame_req,
  input  logic        underflow_clr,
  input  logic        test_pat_sel,
  output logic [4:0]  vga_r,
  output logic [5:0]  vga_g,
  output logic [4:0]  vga_b,
  output logic        vga_hs_o,
  output logic        vga_vs_o,
  output logic        vga_de_o,
  output logic        underflow,
  output logic [15:0] underflow_cnt
);

  localparam logic [9:0] V_ACT_L = 10'(V_ACTIVE);

  // Pixel source, chosen at the pop cycle and carried one stage to meet the
  // FIFO read data.
  localparam logic [1:0] SRC_ZERO = 2'd0;
  localparam logic [1:0] SRC_FIFO = 2'd1;
  localparam logic [1:0] SRC_FILL = 2'd2;
  localparam logic [1:0] SRC_PAT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_RUN     = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        vblank_trig;
  logic        frame_start;
  logic        pat_active;
  logic        pop_ok;
  logic        uf_event;
  logic [1:0]  src_sel;

  logic        hs_d1, vs_d1, de_d1;
  logic [1:0]  src_d1;
  logic [15:0] pix_nxt;

  assign vblank_trig = (vga_paddr_v == V_ACT_L) && (vga_paddr_h == 10'd0);
  assign frame_start = vga_dp_en && (vga_paddr_h == 10'd0) && (vga_paddr_v == 10'd0);

`ifdef VGA_TEST_PATTERN_EN
  logic [15:0] pat_color;
  logic [15:0] pat_d1;

  assign pat_active = test_pat_sel;

  // Eight 80-pixel bars; compare ladder instead of a divide by 80.
  always_comb begin
    pat_color = 16'h0000;
    if      (vga_paddr_h < 10'd80)  pat_color = 16'hFFFF; // white
    else if (vga_paddr_h < 10'd160) pat_color = 16'hFFE0; // yellow
    else if (vga_paddr_h < 10'd240) pat_color = 16'h07FF; // cyan
    else if (vga_paddr_h < 10'd320) pat_color = 16'h07E0; // green
    else if (vga_paddr_h < 10'd400) pat_color = 16'hF81F; // magenta
    else if (vga_paddr_h < 10'd480) pat_color = 16'hF800; // red
    else if (vga_paddr_h < 10'd560) pat_color = 16'h001F; // blue
    else                            pat_color = 16'h0000; // black
  end

  always_ff @(posedge vga_pclk or posedge sys_rst) begin
    if (sys_rst) pat_d1 <= 16'h0000;
    else         pat_d1 <= pat_color;
  end
`else
  logic unused_test_pat_sel;
  assign unused_test_pat_sel = test_pat_sel;
  assign pat_active = 1'b0;
`endif

  always_ff @(posedge vga_pclk or posedge sys_rst) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // The pattern generator owns the picture while selected, so it also masks
  // pops and underflow detection; the state machine keeps tracking frames.
  always_comb begin
    state_nxt = state;
    pop_ok    = 1'b0;
    uf_event  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (vblank_trig) state_nxt = ST_ARM;
      end
      ST_ARM: begin
        if (frame_start) begin
          state_nxt = ST_RUN;
          pop_ok    = 1'b1;
        end
      end
      ST_RUN: begin
        pop_ok = 1'b1;
        if (vga_dp_en && fifo_empty && !pat_active) begin
          state_nxt = ST_RECOVER;
          uf_event  = 1'b1;
        end
      end
      ST_RECOVER: begin
        if (vblank_trig) state_nxt = ST_ARM;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign fifo_rd_en = pop_ok && vga_dp_en && !fifo_empty && !pat_active;

  // The underflowing pixel itself already shows the fill colour.
  always_comb begin
    src_sel = SRC_ZERO;
    if (pat_active)                          src_sel = SRC_PAT;
    else if (fifo_rd_en)                     src_sel = SRC_FIFO;
    else if (uf_event || state == ST_RECOVER) src_sel = SRC_FILL;
  end

  always_ff @(posedge vga_pclk or posedge sys_rst) begin
    if (sys_rst) begin
      frame_req  <= 1'b0;
      fifo_flush <= 1'b0;
    end else begin
      frame_req  <= vblank_trig;
      fifo_flush <= vblank_trig && (state == ST_RECOVER);
    end
  end

  // Stage 1: syncs, DE and source select wait here for the FIFO read data.
  always_ff @(posedge vga_pclk or posedge sys_rst) begin
    if (sys_rst) begin
      hs_d1  <= 1'b1;
      vs_d1  <= 1'b1;
      de_d1  <= 1'b0;
      src_d1 <= SRC_ZERO;
    end else begin
      hs_d1  <= vga_hsync;
      vs_d1  <= vga_vsync;
      de_d1  <= vga_dp_en;
      src_d1 <= src_sel;
    end
  end

  always_comb begin
    pix_nxt = 16'h0000;
    case (src_d1)
      SRC_FIFO: pix_nxt = fifo_dout;
      SRC_FILL: pix_nxt = FILL_COLOR;
`ifdef VGA_TEST_PATTERN_EN
      SRC_PAT:  pix_nxt = pat_d1;
`endif
      default:  pix_nxt = 16'h0000;
    endcase
    if (!de_d1) pix_nxt = 16'h0000;
  end

  // Stage 2: output registers.
  always_ff @(posedge vga_pclk or posedge sys_rst) begin
    if (sys_rst) begin
      vga_r    <= 5'd0;
      vga_g    <= 6'd0;
      vga_b    <= 5'd0;
      vga_hs_o <= 1'b1;
      vga_vs_o <= 1'b1;
      vga_de_o <= 1'b0;
    end else begin
      vga_r    <= pix_nxt[15:11];
      vga_g    <= pix_nxt[10:5];
      vga_b    <= pix_nxt[4:0];
      vga_hs_o <= hs_d1;
      vga_vs_o <= vs_d1;
      vga_de_o <= de_d1;
    end
  end

  // A clear landing on the same cycle as an event leaves exactly that event.
  always_ff @(posedge vga_pclk or posedge sys_rst) begin
    if (sys_rst) begin
      underflow     <= 1'b0;
      underflow_cnt <= 16'd0;
    end else if (uf_event) begin
      underflow <= 1'b1;
      if (underflow_clr)                 underflow_cnt <= 16'd1;
      else if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
    end else if (underflow_clr) begin
      underflow     <= 1'b0;
      underflow_cnt <= 16'd0;
    end
  end

endmodule

// File: tb/tb_vga_pixel_out.sv
`timescale 1ns/1ps
module tb_vga_pixel_out;

  logic        vga_pclk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [9:0]  vga_paddr_h = '0;
  logic [9:0]  vga_paddr_v = '0;
  logic        vga_hsync = 1'b1;
  logic        vga_vsync = 1'b1;
  logic        vga_dp_en = 1'b0;
  logic [15:0] fifo_dout = '0;
  logic        fifo_empty = 1'b0;
  logic        fifo_rd_en, fifo_flush, frame_req;
  logic        underflow_clr = 1'b0;
  logic        test_pat_sel = 1'b0;
  logic [4:0]  vga_r;
  logic [5:0]  vga_g;
  logic [4:0]  vga_b;
  logic        vga_hs_o, vga_vs_o, vga_de_o, underflow;
  logic [15:0] underflow_cnt;

  vga_pixel_out dut (
    .vga_pclk(vga_pclk), .sys_rst(sys_rst),
    .vga_paddr_h(vga_paddr_h), .vga_paddr_v(vga_paddr_v),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_dp_en(vga_dp_en),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_flush(fifo_flush), .frame_req(frame_req),
    .underflow_clr(underflow_clr), .test_pat_sel(test_pat_sel),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs_o(vga_hs_o), .vga_vs_o(vga_vs_o), .vga_de_o(vga_de_o),
    .underflow(underflow), .underflow_cnt(underflow_cnt)
  );

  always #5 vga_pclk = ~vga_pclk;

  int cyc = 0;
  always @(posedge vga_pclk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          h;
    int          v;
    logic        hs;
    logic        vs;
    logic        de;
    logic [15:0] rgb;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // bench view of the controller: 0 idle, 1 armed, 2 running, 3 recovering
  int          bm = 0;
  int          exp_cnt = 0;
  bit          exp_flag = 0;
  logic [15:0] word = 16'h1000;
  int          pops_exp = 0;
  int          pops_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [15:0] bar(input int h);
    logic [15:0] tbl [8];
    tbl = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    return tbl[h / 80];
  endfunction

  // scoreboard monitor: compares every output cycle that has an expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge vga_pclk);
      #2;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk($sformatf("hs_o v%0d h%0d", e.v, e.h), vga_hs_o, e.hs);
        chk($sformatf("vs_o v%0d h%0d", e.v, e.h), vga_vs_o, e.vs);
        chk($sformatf("de_o v%0d h%0d", e.v, e.h), vga_de_o, e.de);
        chk($sformatf("rgb v%0d h%0d", e.v, e.h), {vga_r, vga_g, vga_b}, e.rgb);
      end
    end
  end

  task automatic px(input int h, input int v, input bit empty, input bit clr);
    bit dp, hs, vs, fr, fl, pop, pat, act_pop;
    logic [15:0] val;
    exp_t e;
    pat = 0;
`ifdef VGA_TEST_PATTERN_EN
    pat = test_pat_sel;
`endif
    dp = (h < 640) && (v < 480);
    hs = !(h >= 656 && h < 752);
    vs = !(v >= 490 && v < 492);
    fr = (v == 480) && (h == 0);
    fl = fr && (bm == 3);
    pop = 0;
    val = 16'h0000;
    if (fr && (bm == 0 || bm == 3)) bm = 1;
    if (clr) begin
      exp_cnt = 0;
      exp_flag = 0;
    end
    if (dp) begin
      if (bm == 1 && h == 0 && v == 0) begin
        bm = 2;
        pop = !empty && !pat;
        val = pat ? bar(h) : (pop ? word : 16'h0000);
      end else if (bm == 2) begin
        if (pat) val = bar(h);
        else if (empty) begin
          val = 16'h001F;
          bm = 3;
          exp_flag = 1;
          exp_cnt = clr ? 1 : ((exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 1);
        end else begin
          pop = 1;
          val = word;
        end
      end else if (bm == 3) val = pat ? bar(h) : 16'h001F;
      else val = pat ? bar(h) : 16'h0000;
    end
    if (pop) pops_exp++;
    vga_paddr_h = 10'(h);
    vga_paddr_v = 10'(v);
    vga_dp_en = dp;
    vga_hsync = hs;
    vga_vsync = vs;
    fifo_empty = empty;
    underflow_clr = clr;
    #1;
    act_pop = fifo_rd_en;
    chk($sformatf("rd_en v%0d h%0d", v, h), act_pop, pop);
    e.due = cyc + 2;
    e.h = h;
    e.v = v;
    e.hs = hs;
    e.vs = vs;
    e.de = dp;
    e.rgb = val;
    sb.push_back(e);
    @(posedge vga_pclk);
    #1;
    if (act_pop) begin
      fifo_dout = word;
      word = word + 16'd1;
      pops_seen++;
    end
    chk($sformatf("frame_req v%0d h%0d", v, h), frame_req, fr);
    chk($sformatf("fifo_flush v%0d h%0d", v, h), fifo_flush, fl);
    chk($sformatf("underflow v%0d h%0d", v, h), underflow, exp_flag);
    chk($sformatf("underflow_cnt v%0d h%0d", v, h), underflow_cnt, exp_cnt);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " rgb"}, {vga_r, vga_g, vga_b}, 16'h0000);
    chk({tag, " hs_o"}, vga_hs_o, 1'b1);
    chk({tag, " vs_o"}, vga_vs_o, 1'b1);
    chk({tag, " de_o"}, vga_de_o, 1'b0);
    chk({tag, " frame_req"}, frame_req, 1'b0);
    chk({tag, " fifo_flush"}, fifo_flush, 1'b0);
    chk({tag, " underflow"}, underflow, 1'b0);
    chk({tag, " underflow_cnt"}, underflow_cnt, 16'h0000);
    chk({tag, " rd_en"}, fifo_rd_en, 1'b0);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    sb.delete();
    #1;
    check_reset_vals("midline_reset");
    @(posedge vga_pclk);
    #1;
    sys_rst = 1'b0;
    bm = 0;
    exp_cnt = 0;
    exp_flag = 0;
  endtask

  // sparse frame: a handful of lines and pixels, including sync edges
  task automatic frame(input int uf_v, input int uf_h, input bit clr_uf,
                       input int rst_v, input int rst_h);
    int hl [16];
    int vl [5];
    int bl [6];
    int bh [4];
    bit empty, clr;
    hl = '{0, 1, 2, 79, 80, 99, 100, 101, 102, 639, 640, 655, 656, 751, 752, 799};
    vl = '{0, 1, 200, 201, 479};
    bl = '{480, 481, 490, 491, 492, 524};
    bh = '{0, 1, 656, 799};
    pops_exp = 0;
    pops_seen = 0;
    foreach (vl[vi]) begin
      foreach (hl[hi]) begin
        if (vl[vi] == rst_v && hl[hi] == rst_h) do_reset();
        empty = (uf_v >= 0) &&
                ((vl[vi] == uf_v && hl[hi] >= uf_h && hl[hi] <= uf_h + 2) ||
                 (vl[vi] == uf_v + 1 && hl[hi] == 0));
        clr = clr_uf && vl[vi] == uf_v && hl[hi] == uf_h;
        px(hl[hi], vl[vi], empty, clr);
      end
    end
    chk("pops_per_frame", pops_seen, pops_exp);
    foreach (bl[vi]) begin
      foreach (bh[hi]) px(bh[hi], bl[vi], 1'b0, 1'b0);
    end
  endtask

  initial begin
    #12;
    check_reset_vals("reset");
    @(posedge vga_pclk);
    #1;
    sys_rst = 1'b0;
    frame(-1, -1, 0, -1, -1);        // unarmed: no pops, zero pixels; arms at vblank
    frame(-1, -1, 0, -1, -1);        // normal streaming
    chk("normal_pop_count", pops_seen, 50);
    frame(200, 100, 0, -1, -1);      // underflow at (h100,v200) plus 3 more empties
    chk("uf_cnt_after_frame", underflow_cnt, 16'd1);
    frame(-1, -1, 0, -1, -1);        // flush seen at prior vblank; data resumes
    chk("resume_pop_count", pops_seen, 50);
    frame(200, 100, 1, -1, -1);      // clear coincident with new event
    chk("clr_event_cnt", underflow_cnt, 16'd1);
    chk("clr_event_flag", underflow, 1'b1);
    frame(-1, -1, 0, 1, 2);          // reset mid-line, no pops until re-armed
    frame(-1, -1, 0, -1, -1);
    chk("post_reset_pop_count", pops_seen, 50);
`ifdef VGA_TEST_PATTERN_EN
    test_pat_sel = 1'b1;
    frame(200, 100, 0, -1, -1);      // bars, no pops, empties ignored
    chk("pattern_pop_count", pops_seen, 0);
    test_pat_sel = 1'b0;
`endif
    repeat (3) @(posedge vga_pclk);
    #3;
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
